// File: rtl/alu_ctrl_pkg.sv
// Shared ALU opcode, funct and ALU control encodings for the control unit and the ALU.
// Importing this package from both sides keeps the operation encodings consistent.
package alu_ctrl_pkg;

    typedef logic [1:0] aluop_t;
    typedef logic [5:0] func_t;
    typedef logic [3:0] aluctrl_t;

    localparam aluop_t ALUOP_MEM   = 2'b00;
    localparam aluop_t ALUOP_BR    = 2'b01;
    localparam aluop_t ALUOP_RTYPE = 2'b10;
    localparam aluop_t ALUOP_RSVD  = 2'b11;

    localparam func_t F_ADD = 6'b100000;
    localparam func_t F_SUB = 6'b100010;
    localparam func_t F_AND = 6'b100100;
    localparam func_t F_OR  = 6'b100101;
    localparam func_t F_NOR = 6'b100111;
    localparam func_t F_SLT = 6'b101010;

    localparam aluctrl_t ALU_AND = 4'b0000;
    localparam aluctrl_t ALU_OR  = 4'b0001;
    localparam aluctrl_t ALU_ADD = 4'b0010;
    localparam aluctrl_t ALU_SUB = 4'b0110;
    localparam aluctrl_t ALU_SLT = 4'b0111;
    localparam aluctrl_t ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALU control decode (aluop, func -> ctrl, illegal).
// Macro ALU_CTRL_NOR_EN adds the R-type NOR funct; otherwise that funct is unsupported.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  aluop_t   aluop,
    input  func_t    func,
    output aluctrl_t ctrl,
    output logic     illegal
);

    // aluop is decoded first so func cannot influence non-R-type results.
    always_comb begin
        ctrl    = ALU_ADD;
        illegal = 1'b0;
        case (aluop)
            ALUOP_MEM: ctrl = ALU_ADD;
            ALUOP_BR:  ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (func)
                    F_ADD: ctrl = ALU_ADD;
                    F_SUB: ctrl = ALU_SUB;
                    F_AND: ctrl = ALU_AND;
                    F_OR:  ctrl = ALU_OR;
                    F_SLT: ctrl = ALU_SLT;
`ifdef ALU_CTRL_NOR_EN
                    F_NOR: ctrl = ALU_NOR;
`endif
                    default: begin
                        ctrl    = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl    = ALU_ADD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control_unit.sv
// Registered ALU control unit: decodes aluop/func into the ALU select with one cycle latency.
// Macro ALU_CTRL_NOR_EN (handled in alu_ctrl_decode) enables the NOR funct.
module alu_control_unit
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W = 6,
    parameter int OP_W   = 2,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FUNC_W-1:0] func,
    input  logic [OP_W-1:0]   aluop,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              illegal
);

    aluctrl_t dec_ctrl;
    logic     dec_illegal;

    aluctrl_t alucontrol_d, alucontrol_q;
    logic     illegal_d, illegal_q;

    alu_ctrl_decode u_decode (
        .aluop   (aluop),
        .func    (func),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_comb begin
        alucontrol_d = dec_ctrl;
        illegal_d    = dec_illegal;
        if (rst) begin
            alucontrol_d = ALU_ADD;
            illegal_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        alucontrol_q <= alucontrol_d;
        illegal_q    <= illegal_d;
    end

    assign alucontrol = alucontrol_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit using a table-driven reference decode.
// Build with ALU_CTRL_NOR_EN defined to exercise the NOR funct.
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] func;
    logic [1:0] aluop;
    logic [3:0] alucontrol;
    logic       illegal;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] RT_FUNC [0:5] = '{6'b100000, 6'b100010, 6'b100100,
                                             6'b100101, 6'b101010, 6'b100111};
    localparam logic [3:0] RT_CTRL [0:5] = '{4'b0010, 4'b0110, 4'b0000,
                                             4'b0001, 4'b0111, 4'b1100};
`ifdef ALU_CTRL_NOR_EN
    localparam int RT_N = 6;
`else
    localparam int RT_N = 5;
`endif

    alu_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .func       (func),
        .aluop      (aluop),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Reference: memory ops add, branches subtract, R-type looks up the funct table.
    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                       output logic [3:0] c, output logic il);
        c  = 4'b0010;
        il = 1'b0;
        if (op == 2'd0) c = 4'b0010;
        else if (op == 2'd1) c = 4'b0110;
        else if (op == 2'd2) begin
            il = 1'b1;
            for (int i = 0; i < RT_N; i++) begin
                if (RT_FUNC[i] == f) begin
                    c  = RT_CTRL[i];
                    il = 1'b0;
                end
            end
        end else il = 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] exp_c, input logic exp_il);
        n_cmp++;
        if (alucontrol !== exp_c || illegal !== exp_il) begin
            n_err++;
            $display("FAIL %s: got ctrl=%b illegal=%b, expected ctrl=%b illegal=%b",
                     name, alucontrol, illegal, exp_c, exp_il);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        aluop = 2'b10;
        func  = 6'b100010;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0010 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_c1: got %b/%b expected 0010/0", alucontrol, illegal);
        end
        step();
        n_cmp++;
        if (alucontrol !== 4'b0010 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_c2: got %b/%b expected 0010/0", alucontrol, illegal);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0110 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got %b/%b expected 0110/0", alucontrol, illegal);
        end
    endtask

    task automatic test_non_rtype();
        aluop = 2'b00;
        func  = 6'bxxxxxx;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0010 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL mem_op: got %b/%b expected 0010/0", alucontrol, illegal);
        end
        aluop = 2'b01;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0110 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL branch_op: got %b/%b expected 0110/0", alucontrol, illegal);
        end
        // funct values that are legal R-type codes must still be ignored here.
        aluop = 2'b00;
        func  = 6'b100100;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0010 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL mem_op_func_and: got %b/%b expected 0010/0", alucontrol, illegal);
        end
        aluop = 2'b01;
        func  = 6'b000000;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0110 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL branch_op_func_zero: got %b/%b expected 0110/0", alucontrol, illegal);
        end
    endtask

    task automatic test_rtype_sweep();
        logic [5:0] fs [0:4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [3:0] cs [0:4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        for (int i = 0; i < 5; i++) begin
            aluop = 2'b10;
            func  = fs[i];
            step();
            n_cmp++;
            if (alucontrol !== cs[i] || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL rtype_%b: got %b/%b expected %b/0", fs[i], alucontrol, illegal, cs[i]);
            end
        end
    endtask

    task automatic test_illegal();
        aluop = 2'b10;
        func  = 6'b000000;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0010 || illegal !== 1'b1) begin
            n_err++;
            $display("FAIL rtype_bad_func: got %b/%b expected 0010/1", alucontrol, illegal);
        end
        for (int i = 0; i < 4; i++) begin
            aluop = 2'b11;
            func  = 6'($urandom);
            if (i == 0) func = 6'b100010;
            step();
            n_cmp++;
            if (alucontrol !== 4'b0010 || illegal !== 1'b1) begin
                n_err++;
                $display("FAIL rsvd_op func=%b: got %b/%b expected 0010/1", func, alucontrol, illegal);
            end
        end
    endtask

    task automatic test_optional();
        aluop = 2'b10;
        func  = 6'b100111;
        step();
        n_cmp++;
`ifdef ALU_CTRL_NOR_EN
        if (alucontrol !== 4'b1100 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL nor_func: got %b/%b expected 1100/0", alucontrol, illegal);
        end
`else
        if (alucontrol !== 4'b0010 || illegal !== 1'b1) begin
            n_err++;
            $display("FAIL nor_func: got %b/%b expected 0010/1", alucontrol, illegal);
        end
`endif
    endtask

    // New vector every cycle; the output after edge n+1 must match the vector applied before edge n+1.
    task automatic test_back_to_back(input int n, input bit legal_only);
        logic [3:0] exp_c;
        logic       exp_il;
        logic [1:0] op;
        logic [5:0] f;
        for (int k = 0; k < n; k++) begin
            if (legal_only) begin
                op = 2'($urandom_range(0, 2));
                f  = (op == 2'd2) ? RT_FUNC[$urandom_range(0, RT_N - 1)] : 6'($urandom);
            end else begin
                op = 2'($urandom);
                f  = ($urandom_range(0, 1) == 1) ? RT_FUNC[$urandom_range(0, 5)] : 6'($urandom);
            end
            aluop = op;
            func  = f;
            ref_decode(op, f, exp_c, exp_il);
            step();
            // Glitch inputs between edges; registered outputs must hold.
            aluop = 2'($urandom);
            func  = 6'($urandom);
            #2;
            n_cmp++;
            if (alucontrol !== exp_c || illegal !== exp_il) begin
                n_err++;
                $display("FAIL latency[%0d] op=%b func=%b: got %b/%b expected %b/%b",
                         k, op, f, alucontrol, illegal, exp_c, exp_il);
            end
        end
    endtask

    task automatic test_reset_priority();
        rst   = 1'b1;
        aluop = 2'b11;
        func  = 6'b111111;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0010 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_priority: got %b/%b expected 0010/0", alucontrol, illegal);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (alucontrol !== 4'b0010 || illegal !== 1'b1) begin
            n_err++;
            $display("FAIL reset_priority_release: got %b/%b expected 0010/1", alucontrol, illegal);
        end
    endtask

    initial begin
        rst   = 1'b1;
        aluop = 2'b00;
        func  = 6'b000000;
        #1;
        test_reset();
        test_non_rtype();
        test_rtype_sweep();
        test_illegal();
        test_optional();
        test_back_to_back(20, 1'b1);
        test_back_to_back(40, 1'b0);
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Decodes the 2-bit main-decoder ALU opcode and the 6-bit R-type funct field into the 4-bit ALU operation select for the single-cycle MIPS-style CPU datapath.
- Sits between the main control unit / instruction register and the ALU.
- The decode is purely combinational, then registered.
- Also flags unsupported funct/opcode combinations.

Parameters:
- FUNC_W, 6, width of funct field
- OP_W, 2, width of ALU opcode
- CTRL_W, 4, width of ALU control output

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- func  in  6  instruction funct field (bits [5:0]); don't-care unless aluop=10
- aluop  in  2  ALU opcode from main control
- alucontrol  out  4  registered ALU operation select
- illegal  out  1  registered flag; 1 when the decoded combination is unsupported

Behaviour:
- Encoding constants: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- Combinational decode:
  - aluop=00 -> ADD (load/store address), func ignored.
  - aluop=01 -> SUB (branch compare), func ignored.
  - aluop=10 -> R-type by func:
    - 100000 -> ADD
    - 100010 -> SUB
    - 100100 -> AND
    - 100101 -> OR
    - 101010 -> SLT
    - any other func -> ADD with illegal=1
  - aluop=11 -> ADD with illegal=1 (reserved).
- X/Z on func while aluop is 00/01 must not propagate: the output is fully determined by aluop. Implement with an explicit aluop-first case, not a concatenated casez.
- Registering: alucontrol and illegal update on every rising clk edge from the decode of the current inputs. Latency is exactly 1 cycle; there is no enable and no handshake.
- Reset: while rst=1 at a rising edge, alucontrol<=0010 (ADD) and illegal<=0. Reset has priority over decode.
- On the first edge after rst deasserts, the outputs reflect the inputs sampled at that edge.
- Outputs hold between edges even if inputs glitch.
- Decode is exhaustive: every input combination yields a defined output; no latches.

Optional Feature:
- Macro ALU_CTRL_NOR_EN.
- When defined: aluop=10 with func=100111 decodes to NOR (1100), illegal=0.
- When undefined: func=100111 is an unsupported funct -> ADD, illegal=1.
- All other decodes are identical in both builds.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALU opcode constants: ALUOP_MEM=00, ALUOP_BR=01, ALUOP_RTYPE=10, ALUOP_RSVD=11.
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_NOR.
  - ALU control encodings: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - typedefs aluop_t (2b), func_t (6b), aluctrl_t (4b).
- One natural sub-module: alu_ctrl_decode, the pure combinational function (aluop, func -> ctrl, illegal). The top instantiates it and adds the output register.
- The ALU must import the same package so the encodings stay consistent.

Test Plan:
- Reset: assert rst for 2 cycles with aluop=10, func=100010 -> alucontrol=0010, illegal=0 during reset; one edge after release -> 0110.
- Non-R-type: aluop=00, func=xxxxxx -> 0010 after 1 edge; aluop=01, func=xxxxxx -> 0110; illegal=0 and no X on outputs in both cases.
- R-type sweep at aluop=10, each checked one cycle after apply with illegal=0:
  - func 100000 -> 0010
  - func 100010 -> 0110
  - func 100100 -> 0000
  - func 100101 -> 0001
  - func 101010 -> 0111
- Illegal cases: aluop=10 with func=000000 -> 0010, illegal=1; aluop=11 with any func -> 0010, illegal=1.
- Optional feature: aluop=10, func=100111 -> 1100, illegal=0 when built with ALU_CTRL_NOR_EN; 0010, illegal=1 when built without.
- Latency: change inputs every cycle over 20 random legal vectors -> output at edge n+1 always equals the reference decode of the inputs sampled at edge n.
